// File: rtl/regfile_write_arbiter.sv
// Four-requester round-robin write arbiter for a register-file write port,
// with optional locked bursts of up to MAX_BURST consecutive beats.
module regfile_write_arbiter #(
    parameter int DATA_W    = 8,
    parameter int MAX_BURST = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [3:0]          req,
    input  logic [3:0]          lock,
    input  logic [4*DATA_W-1:0] wdata,
    output logic [3:0]          gnt,
    output logic                wr_en,
    output logic [1:0]          wr_sel,
    output logic [3:0]          wr_onehot,
    output logic [DATA_W-1:0]   wr_data,
    output logic                busy
);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    // Beat counter holds (beats already granted - 1), so a burst may extend
    // while it is below MAX_BURST-1.
    localparam logic [3:0] BEAT_LAST = 4'(MAX_BURST - 1);

    state_t              state_r;
    logic [1:0]          ptr_r;
    logic [3:0]          beat_cnt_r;

    logic                hold_s;
    logic [1:0]          rr_start_s;
    logic [2:0]          pick_s;
    logic [1:0]          data_idx_s;
    logic [DATA_W-1:0]   data_s;

    // Returns {found, index} of the first set request at or above start, wrapping 3->0.
    function automatic logic [2:0] rr_pick(input logic [3:0] r, input logic [1:0] start);
        logic [2:0] res;
        logic [1:0] idx;
        res = 3'b000;
        for (int i = 3; i >= 0; i--) begin
            idx = start + 2'(i);
            res = r[idx] ? {1'b1, idx} : res;
        end
        return res;
    endfunction

    // Two-to-four decode of a register index.
    function automatic logic [3:0] dec_onehot(input logic [1:0] idx);
        logic [3:0] res;
        case (idx)
            2'd0:    res = 4'b0001;
            2'd1:    res = 4'b0010;
            2'd2:    res = 4'b0100;
            2'd3:    res = 4'b1000;
            default: res = 4'b0000;
        endcase
        return res;
    endfunction

    // Burst-continue decision and round-robin start point; a finishing grant
    // arbitrates from the pointer it is about to leave behind.
    always_comb begin
        hold_s     = 1'b0;
        rr_start_s = ptr_r;
        case (state_r)
            ST_GRANT: begin
                hold_s     = req[wr_sel] & lock[wr_sel] & (beat_cnt_r < BEAT_LAST);
                rr_start_s = wr_sel + 2'd1;
            end
            ST_IDLE: begin
                hold_s     = 1'b0;
                rr_start_s = ptr_r;
            end
            default: begin
                hold_s     = 1'b0;
                rr_start_s = ptr_r;
            end
        endcase
    end

    // Winner selection and write-data mux for the beat issued at this edge.
    always_comb begin
        pick_s = rr_pick(req, rr_start_s);
        if (hold_s) begin
            data_idx_s = wr_sel;
        end else begin
            data_idx_s = pick_s[1:0];
        end
        data_s = wdata[int'(data_idx_s)*DATA_W +: DATA_W];
    end

    // Arbitration FSM with registered grant and write-port outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= ST_IDLE;
            ptr_r      <= 2'd0;
            beat_cnt_r <= 4'd0;
            gnt        <= 4'b0000;
            wr_en      <= 1'b0;
            wr_sel     <= 2'd0;
            wr_onehot  <= 4'b0000;
            wr_data    <= '0;
            busy       <= 1'b0;
        end else if (hold_s) begin
            beat_cnt_r <= beat_cnt_r + 4'd1;
            wr_data    <= data_s;
        end else begin
            ptr_r <= rr_start_s;
            if (pick_s[2]) begin
                state_r    <= ST_GRANT;
                beat_cnt_r <= 4'd0;
                gnt        <= dec_onehot(pick_s[1:0]);
                wr_en      <= 1'b1;
                wr_sel     <= pick_s[1:0];
                wr_onehot  <= dec_onehot(pick_s[1:0]);
                wr_data    <= data_s;
                busy       <= 1'b1;
            end else begin
                // wr_sel and wr_data keep their last values while idle.
                state_r    <= ST_IDLE;
                beat_cnt_r <= 4'd0;
                gnt        <= 4'b0000;
                wr_en      <= 1'b0;
                wr_onehot  <= 4'b0000;
                busy       <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Scoreboard bench for regfile_write_arbiter: directed stimulus queues the
// expected beats; a negedge monitor pops and compares each presented beat.
module tb_regfile_write_arbiter;

    localparam int DATA_W = 8;

    logic                clk;
    logic                rst_n;
    logic [3:0]          req;
    logic [3:0]          lock;
    logic [4*DATA_W-1:0] wdata;
    logic [3:0]          gnt;
    logic                wr_en;
    logic [1:0]          wr_sel;
    logic [3:0]          wr_onehot;
    logic [DATA_W-1:0]   wr_data;
    logic                busy;

    logic [DATA_W-1:0]   d [4];

    typedef struct {
        int              cyc;
        logic [1:0]      idx;
        logic [DATA_W-1:0] data;
    } beat_t;

    beat_t sb_q[$];
    int    cyc      = 0;
    int    n_checks = 0;
    int    n_fail   = 0;

    assign wdata = {d[3], d[2], d[1], d[0]};

    regfile_write_arbiter #(.DATA_W(DATA_W), .MAX_BURST(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .lock      (lock),
        .wdata     (wdata),
        .gnt       (gnt),
        .wr_en     (wr_en),
        .wr_sel    (wr_sel),
        .wr_onehot (wr_onehot),
        .wr_data   (wr_data),
        .busy      (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Queue a beat for requester idx expected 'off' cycles after the current one.
    task automatic expect_beat(input int off, input int idx);
        beat_t b;
        b.cyc  = cyc + off;
        b.idx  = 2'(idx);
        b.data = d[idx];
        sb_q.push_back(b);
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Monitor: per-cycle output consistency plus scoreboard match on every beat.
    always @(negedge clk) begin
        beat_t b;
        chk("onehot_or_zero", 32'($countones(wr_onehot) <= 1), 32'd1);
        chk("onehot_eq_gnt", 32'(wr_onehot), 32'(gnt));
        chk("busy_eq_wr_en", 32'(busy), 32'(wr_en));
        chk("wr_en_eq_or_gnt", 32'(wr_en), 32'(|gnt));
        if (wr_en === 1'b1) begin
            if (sb_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_beat: gnt=0x%0h at cycle %0d, expected no beat", gnt, cyc);
            end else begin
                b = sb_q.pop_front();
                chk("beat_cycle", 32'(cyc), 32'(b.cyc));
                chk("beat_gnt", 32'(gnt), 32'(4'b0001 << b.idx));
                chk("beat_wr_sel", 32'(wr_sel), 32'(b.idx));
                chk("beat_wr_data", 32'(wr_data), 32'(b.data));
            end
        end
    end

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_gnt"}, 32'(gnt), 32'd0);
        chk({tag, "_wr_en"}, 32'(wr_en), 32'd0);
        chk({tag, "_wr_sel"}, 32'(wr_sel), 32'd0);
        chk({tag, "_wr_onehot"}, 32'(wr_onehot), 32'd0);
        chk({tag, "_wr_data"}, 32'(wr_data), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
    endtask

    initial begin
        rst_n = 1'b1;
        req   = 4'b0000;
        lock  = 4'b0000;
        d[0]  = 8'h11;
        d[1]  = 8'h22;
        d[2]  = 8'hA5;
        d[3]  = 8'h3C;
        #1 rst_n = 1'b0;
        #2 chk_reset_outputs("reset");
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        // Alternating single beats for requesters 0 and 2; leaves ptr at 3.
        req = 4'b0101;
        expect_beat(1, 0);
        expect_beat(2, 2);
        expect_beat(3, 0);
        expect_beat(4, 2);
        repeat (4) tick();
        req = 4'b0000;
        tick();
        tick();

        // Wrap-around from ptr 3 with all requesting; leaves ptr at 0.
        req = 4'b1111;
        expect_beat(1, 3);
        expect_beat(2, 0);
        expect_beat(3, 1);
        expect_beat(4, 2);
        expect_beat(5, 3);
        repeat (5) tick();
        req = 4'b0000;
        tick();
        tick();

        // Locked burst by requester 3: four beats, forced release, immediate re-win.
        req  = 4'b1000;
        lock = 4'b1000;
        for (int i = 0; i < 5; i++) begin
            d[3] = 8'h40 + 8'(i);
            expect_beat(1, 3);
            tick();
        end
        req  = 4'b0000;
        lock = 4'b0000;
        tick();
        tick();

        // Same burst, but requester 0 joins and takes the fifth beat.
        d[3] = 8'h3C;
        req  = 4'b1000;
        lock = 4'b1000;
        expect_beat(1, 3);
        tick();
        req = 4'b1001;
        expect_beat(1, 3);
        expect_beat(2, 3);
        expect_beat(3, 3);
        expect_beat(4, 0);
        repeat (4) tick();
        req  = 4'b0000;
        lock = 4'b0000;
        tick();
        tick();

        // Requester 1 burst cut short by lock drop; requester 2 follows with 0xA5.
        req  = 4'b0110;
        lock = 4'b0010;
        expect_beat(1, 1);
        expect_beat(2, 1);
        tick();
        tick();
        lock = 4'b0000;
        expect_beat(1, 2);
        tick();
        req = 4'b0000;
        tick();
        tick();

        // Asynchronous reset mid-burst, then a fresh grant one cycle after release.
        req  = 4'b0010;
        lock = 4'b0010;
        expect_beat(1, 1);
        expect_beat(2, 1);
        tick();
        tick();
        @(negedge clk);
        #1 rst_n = 1'b0;
        lock = 4'b0000;
        #1 chk_reset_outputs("midburst_reset");
        #1 rst_n = 1'b1;
        expect_beat(1, 1);
        tick();
        req = 4'b0000;
        tick();
        tick();
        tick();

        chk("scoreboard_drained", 32'(sb_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/regfile_write_arbiter.md
REGFILE_WRITE_ARBITER -- requirements
Module: regfile_write_arbiter

Interface
REQ-001 SHALL have parameter DATA_W, default 8, write-data width in bits.
REQ-002 SHALL have parameter MAX_BURST, default 4, max consecutive beats one locked requester may hold the port (legal 1..15).
REQ-003 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port req  input  4  per-requester write request, bit i = requester i.
REQ-006 SHALL have port lock  input  4  per-requester burst request, meaningful only with matching req bit.
REQ-007 SHALL have port wdata  input  4*DATA_W  packed write data, requester i at bits [i*DATA_W +: DATA_W].
REQ-008 SHALL have port gnt  output  4  one-hot grant, registered.
REQ-009 SHALL have port wr_en  output  1  register-file write strobe, registered.
REQ-010 SHALL have port wr_sel  output  2  encoded target register number (= granted requester index), registered.
REQ-011 SHALL have port wr_onehot  output  4  decoded register select, bit wr_sel set when wr_en=1, else 0000.
REQ-012 SHALL have port wr_data  output  DATA_W  write data of granted requester, registered.
REQ-013 SHALL have port busy  output  1  high while in GRANT state.

Function
REQ-014 SHALL implement two states: IDLE (no grant) and GRANT (one write beat per cycle).
REQ-015 SHALL, in IDLE with req=0000, remain in IDLE with gnt=0000, wr_en=0.
REQ-016 SHALL, in IDLE with any req bit set, enter GRANT at the next edge with the round-robin winner; request-to-grant latency exactly 1 cycle.
REQ-017 SHALL select the winner as the first set req bit searching from index ptr upward, wrapping 3->0.
REQ-018 SHALL set ptr to (granted index + 1) mod 4 when a grant ends; ptr reset value 0.
REQ-019 SHALL, in GRANT for requester c, continue granting c next cycle iff req[c]=1, lock[c]=1 and beats granted to c so far < MAX_BURST.
REQ-020 SHALL otherwise end c's grant and, if any req bit is set, grant the next winner (using updated ptr) in the immediately following cycle with no IDLE gap; else return to IDLE.
REQ-021 SHALL treat a non-locked requester still holding req after its beat as a new request ranked by the updated ptr (single beat per grant).
REQ-022 SHALL force release after MAX_BURST beats even if req[c] and lock[c] remain high; c regains the port only via round-robin.
REQ-023 SHALL end a burst immediately when req[c] or lock[c] falls; the cycle after the fall carries no beat for c unless c wins round-robin again (non-locked single beat).
REQ-024 SHALL hold gnt, wr_sel, wr_onehot, wr_data mutually consistent: in every GRANT cycle gnt[wr_sel]=1, wr_onehot=gnt, wr_en=1, wr_data=wdata slice sampled at the edge that issued the beat.
REQ-025 SHALL keep wr_data and wr_sel at their last values when wr_en=0 (don't-care for consumers), with gnt=0000 and wr_onehot=0000.
REQ-026 SHALL ignore lock bits whose req bit is 0 and never grant a requester whose req is 0 at the deciding edge.
REQ-027 SHALL use a 4-bit beat counter, cleared on every new grant; no overflow for legal MAX_BURST.

Reset
REQ-028 SHALL, while rst_n=0, immediately force state=IDLE, ptr=0, beat counter=0, gnt=0000, wr_en=0, wr_sel=00, wr_onehot=0000, wr_data=0, busy=0.
REQ-029 SHALL abandon any in-progress burst on reset with no further beat; first edge after rst_n rises arbitrates from ptr=0.

Verification
REQ-030 Bench SHALL cover: after reset, req=0101 held, lock=0 -> gnt 0001, 0100, 0001, 0100 on successive cycles, wr_en continuously 1, wr_sel 0,2,0,2.
REQ-031 Bench SHALL cover: req=1000, lock=1000 held, MAX_BURST=4 -> gnt=1000 for exactly 4 cycles, then (req still 1000) 1 further cycle after release when it re-wins; with req=1001 the fifth beat goes to requester 0.
REQ-032 Bench SHALL cover: wrap-around, ptr=3 with req=1111 lock=0 -> grant order 3,0,1,2,3.
REQ-033 Bench SHALL cover: requester 1 locked burst, lock[1] dropped after beat 2 with req=0110 -> next beat requester 2, wr_data = wdata[2*DATA_W +: DATA_W] (e.g. 8'hA5).
REQ-034 Bench SHALL cover: rst_n pulsed low mid-burst (between edges) -> gnt, wr_en, wr_onehot 0 without a clock edge; after release with req=0010 -> gnt=0010 one cycle later.
REQ-035 Bench SHALL check every cycle: wr_onehot one-hot or zero, wr_onehot=gnt, wr_en=busy=|gnt.
